// File: rtl/sfp_link_ctrl.sv
// sfp_link_ctrl: bring-up and recovery sequencer for one SFP+ SerDes lane.
// Walks PLL lock, TX reset, loss-of-signal debounce, RX reset and CDR/PCS
// block lock, with timeouts and back-off retry. All outputs are registered and
// follow the state register on the same edge.
module sfp_link_ctrl #(
  parameter int unsigned RST_CYCLES     = 64,
  parameter int unsigned LOS_DEBOUNCE   = 1024,
  parameter int unsigned LOCK_TIMEOUT   = 1000000,
  parameter int unsigned BACKOFF_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sfp_los,
  input  logic       pll_lock,
  input  logic       cdr_lock,
  input  logic       block_lock,
  output logic       serdes_tx_rstn,
  output logic       serdes_rx_rstn,
  output logic       sfp_tx_disable,
  output logic       link_up,
  output logic       stats_clear,
  output logic [2:0] state,
  output logic [7:0] retry_cnt
);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_PLL_WAIT = 3'd1,
    ST_TX_RST   = 3'd2,
    ST_LOS_WAIT = 3'd3,
    ST_RX_RST   = 3'd4,
    ST_CDR_WAIT = 3'd5,
    ST_UP       = 3'd6,
    ST_BACKOFF  = 3'd7
  } state_t;

  // Counter reload values: a state lasting N cycles loads N-1 and exits at 0.
  localparam logic [23:0] RST_RLD = 24'(RST_CYCLES - 1);
  localparam logic [23:0] DEB_RLD = 24'(LOS_DEBOUNCE - 1);
  localparam logic [23:0] TO_RLD  = 24'(LOCK_TIMEOUT - 1);
  localparam logic [23:0] BO_RLD  = 24'(BACKOFF_CYCLES - 1);

  logic [3:0]  async_s;
  logic [3:0]  meta_r;
  logic [3:0]  sync_r;
  logic        los_s;
  logic        pll_s;
  logic        cdr_s;
  logic        blk_s;
  state_t      state_r;
  state_t      next_s;
  logic [23:0] cnt_r;
  logic [23:0] cnt_next_s;
  logic        cnt_zero_s;
  logic        pll_drop_s;
  logic        los_watch_s;
  logic [2:0]  out_next_s;

  // Counter value on entry to a state.
  function automatic logic [23:0] reload_val(input state_t s);
    logic [23:0] v;
    case (s)
      ST_PLL_WAIT, ST_CDR_WAIT: v = TO_RLD;
      ST_TX_RST, ST_RX_RST:     v = RST_RLD;
      ST_LOS_WAIT:              v = DEB_RLD;
      ST_BACKOFF:               v = BO_RLD;
      default:                  v = 24'd0;
    endcase
    return v;
  endfunction

  // Per-state pin levels as {tx_rstn, rx_rstn, tx_disable}.
  function automatic logic [2:0] pin_decode(input state_t s);
    logic [2:0] v;
    case (s)
      ST_LOS_WAIT, ST_RX_RST: v = 3'b100;
      ST_CDR_WAIT, ST_UP:     v = 3'b110;
      default:                v = 3'b001;
    endcase
    return v;
  endfunction

  assign async_s    = {block_lock, cdr_lock, pll_lock, sfp_los};
  assign los_s      = sync_r[0];
  assign pll_s      = sync_r[1];
  assign cdr_s      = sync_r[2];
  assign blk_s      = sync_r[3];
  assign cnt_zero_s = (cnt_r == 24'd0);
  // PLL loss only matters once the TX side has been released from PLL wait.
  assign pll_drop_s = !pll_s && (state_r >= ST_TX_RST) && (state_r <= ST_UP);
  // States that react to loss of light (the laser is on).
  assign los_watch_s = (state_r == ST_LOS_WAIT) || (state_r == ST_RX_RST) ||
                       (state_r == ST_CDR_WAIT) || (state_r == ST_UP);
  assign out_next_s = pin_decode(next_s);

  // Two-flop synchronizers; reset to the pessimistic values (no light, no lock).
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 4'b0001;
      sync_r <= 4'b0001;
    end else begin
      meta_r <= async_s;
      sync_r <= meta_r;
    end
  end

  // Next-state selection with priority: disable > PLL loss > LOS > own condition.
  always_comb begin
    next_s = state_r;
    if (!enable) begin
      next_s = ST_OFF;
    end else if (pll_drop_s) begin
      next_s = ST_BACKOFF;
    end else if (los_s && los_watch_s) begin
      next_s = ST_LOS_WAIT;
    end else begin
      case (state_r)
        ST_OFF:      next_s = ST_PLL_WAIT;
        ST_PLL_WAIT: begin
          if (pll_s)           next_s = ST_TX_RST;
          else if (cnt_zero_s) next_s = ST_BACKOFF;
          else                 next_s = ST_PLL_WAIT;
        end
        ST_TX_RST: begin
          if (cnt_zero_s) next_s = ST_LOS_WAIT;
          else            next_s = ST_TX_RST;
        end
        ST_LOS_WAIT: begin
          if (cnt_zero_s) next_s = ST_RX_RST;
          else            next_s = ST_LOS_WAIT;
        end
        ST_RX_RST: begin
          if (cnt_zero_s) next_s = ST_CDR_WAIT;
          else            next_s = ST_RX_RST;
        end
        ST_CDR_WAIT: begin
          // Success wins over a coincident timeout.
          if (cdr_s && blk_s)  next_s = ST_UP;
          else if (cnt_zero_s) next_s = ST_BACKOFF;
          else                 next_s = ST_CDR_WAIT;
        end
        ST_UP: begin
          if (!cdr_s || !blk_s) next_s = ST_BACKOFF;
          else                  next_s = ST_UP;
        end
        ST_BACKOFF: begin
          if (cnt_zero_s) next_s = ST_PLL_WAIT;
          else            next_s = ST_BACKOFF;
        end
        default: next_s = ST_OFF;
      endcase
    end
  end

  // Shared down-counter: reload on any state change or on a LOS debounce restart.
  always_comb begin
    cnt_next_s = cnt_r;
    if (next_s != state_r) begin
      cnt_next_s = reload_val(next_s);
    end else if ((state_r == ST_LOS_WAIT) && los_s) begin
      cnt_next_s = DEB_RLD;
    end else if (!cnt_zero_s) begin
      cnt_next_s = cnt_r - 24'd1;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // State, counter and registered outputs, all decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_OFF;
      cnt_r          <= 24'd0;
      serdes_tx_rstn <= 1'b0;
      serdes_rx_rstn <= 1'b0;
      sfp_tx_disable <= 1'b1;
      link_up        <= 1'b0;
      stats_clear    <= 1'b0;
      retry_cnt      <= 8'd0;
    end else begin
      state_r        <= next_s;
      cnt_r          <= cnt_next_s;
      serdes_tx_rstn <= out_next_s[2];
      serdes_rx_rstn <= out_next_s[1];
      sfp_tx_disable <= out_next_s[0];
      link_up        <= (next_s == ST_UP);
      stats_clear    <= (next_s == ST_UP) && (state_r != ST_UP);
      if ((next_s == ST_BACKOFF) && (state_r != ST_BACKOFF) && (retry_cnt != 8'd255)) begin
        retry_cnt <= retry_cnt + 8'd1;
      end else begin
        retry_cnt <= retry_cnt;
      end
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_sfp_link_ctrl.sv
// Directed self-checking bench for sfp_link_ctrl with short timing parameters.
module tb_sfp_link_ctrl;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       sfp_los;
  logic       pll_lock;
  logic       cdr_lock;
  logic       block_lock;
  logic       serdes_tx_rstn;
  logic       serdes_rx_rstn;
  logic       sfp_tx_disable;
  logic       link_up;
  logic       stats_clear;
  logic [2:0] state;
  logic [7:0] retry_cnt;

  int errors = 0;
  int checks = 0;

  logic [2:0] st_a [0:31];
  logic       tx_a [0:31];
  logic       rx_a [0:31];
  logic       dis_a[0:31];
  logic       lu_a [0:31];
  logic       sc_a [0:31];

  sfp_link_ctrl #(
    .RST_CYCLES(4),
    .LOS_DEBOUNCE(8),
    .LOCK_TIMEOUT(100),
    .BACKOFF_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .sfp_los(sfp_los),
    .pll_lock(pll_lock),
    .cdr_lock(cdr_lock),
    .block_lock(block_lock),
    .serdes_tx_rstn(serdes_tx_rstn),
    .serdes_rx_rstn(serdes_rx_rstn),
    .sfp_tx_disable(sfp_tx_disable),
    .link_up(link_up),
    .stats_clear(stats_clear),
    .state(state),
    .retry_cnt(retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (state === target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic record(input int n);
    for (int i = 1; i <= n; i++) begin
      step();
      st_a[i]  = state;
      tx_a[i]  = serdes_tx_rstn;
      rx_a[i]  = serdes_rx_rstn;
      dis_a[i] = sfp_tx_disable;
      lu_a[i]  = link_up;
      sc_a[i]  = stats_clear;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; sfp_los = 1'b1;
    pll_lock = 1'b0; cdr_lock = 1'b0; block_lock = 1'b0;
    repeat (3) step();
    checks++; if (serdes_tx_rstn !== 1'b0) begin errors++; $display("FAIL reset_tx_rstn: got %b expected 0", serdes_tx_rstn); end
    checks++; if (serdes_rx_rstn !== 1'b0) begin errors++; $display("FAIL reset_rx_rstn: got %b expected 0", serdes_rx_rstn); end
    checks++; if (sfp_tx_disable !== 1'b1) begin errors++; $display("FAIL reset_tx_disable: got %b expected 1", sfp_tx_disable); end
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL reset_link_up: got %b expected 0", link_up); end
    checks++; if (stats_clear !== 1'b0) begin errors++; $display("FAIL reset_stats_clear: got %b expected 0", stats_clear); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (retry_cnt !== 8'd0) begin errors++; $display("FAIL reset_retry: got %0d expected 0", retry_cnt); end
    rst = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_clean_bringup();
    int sc_count;
    enable = 1'b0; sfp_los = 1'b0;
    pll_lock = 1'b1; cdr_lock = 1'b1; block_lock = 1'b1;
    apply_reset();
    enable = 1'b1;
    record(24);
    sc_count = 0;
    for (int i = 1; i <= 24; i++) if (sc_a[i] === 1'b1) sc_count++;
    checks++; if (st_a[1] !== 3'd1) begin errors++; $display("FAIL bringup_pll_wait: got %0d expected 1", st_a[1]); end
    checks++; if (st_a[2] !== 3'd2) begin errors++; $display("FAIL bringup_tx_rst_start: got %0d expected 2", st_a[2]); end
    checks++; if (st_a[5] !== 3'd2) begin errors++; $display("FAIL bringup_tx_rst_end: got %0d expected 2", st_a[5]); end
    checks++; if (tx_a[5] !== 1'b0) begin errors++; $display("FAIL bringup_tx_rstn_low: got %b expected 0", tx_a[5]); end
    checks++; if (dis_a[5] !== 1'b1) begin errors++; $display("FAIL bringup_disable_held: got %b expected 1", dis_a[5]); end
    checks++; if (tx_a[6] !== 1'b1) begin errors++; $display("FAIL bringup_tx_rstn_release: got %b expected 1", tx_a[6]); end
    checks++; if (dis_a[6] !== 1'b0) begin errors++; $display("FAIL bringup_disable_fall: got %b expected 0", dis_a[6]); end
    checks++; if (st_a[6] !== 3'd3) begin errors++; $display("FAIL bringup_los_wait: got %0d expected 3", st_a[6]); end
    checks++; if (rx_a[17] !== 1'b0) begin errors++; $display("FAIL bringup_rx_rstn_low: got %b expected 0", rx_a[17]); end
    checks++; if (rx_a[18] !== 1'b1) begin errors++; $display("FAIL bringup_rx_rstn_rise: got %b expected 1", rx_a[18]); end
    checks++; if (lu_a[18] !== 1'b0) begin errors++; $display("FAIL bringup_link_early: got %b expected 0", lu_a[18]); end
    checks++; if (lu_a[19] !== 1'b1) begin errors++; $display("FAIL bringup_link_up: got %b expected 1", lu_a[19]); end
    checks++; if (sc_a[19] !== 1'b1) begin errors++; $display("FAIL bringup_stats_clear: got %b expected 1", sc_a[19]); end
    checks++; if (sc_count !== 1) begin errors++; $display("FAIL bringup_stats_pulses: got %0d expected 1", sc_count); end
    checks++; if (retry_cnt !== 8'd0) begin errors++; $display("FAIL bringup_retry: got %0d expected 0", retry_cnt); end
  endtask

  task automatic test_los_glitch();
    bit ok;
    enable = 1'b0; sfp_los = 1'b1;
    pll_lock = 1'b1; cdr_lock = 1'b1; block_lock = 1'b1;
    apply_reset();
    enable = 1'b1;
    wait_state(3'd3, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL glitch_reach_los_wait: got state %0d expected 3", state); end
    sfp_los = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 6) sfp_los = 1'b1;
      else if (i == 7) sfp_los = 1'b0;
      st_a[i] = state;
    end
    checks++; if (st_a[10] !== 3'd3) begin errors++; $display("FAIL glitch_no_early_exit: got %0d expected 3", st_a[10]); end
    checks++; if (st_a[16] !== 3'd3) begin errors++; $display("FAIL glitch_still_debouncing: got %0d expected 3", st_a[16]); end
    checks++; if (st_a[17] !== 3'd4) begin errors++; $display("FAIL glitch_rx_rst_entry: got %0d expected 4", st_a[17]); end
  endtask

  task automatic test_pll_never_locks();
    int last;
    enable = 1'b0; sfp_los = 1'b1;
    pll_lock = 1'b0; cdr_lock = 1'b0; block_lock = 1'b0;
    apply_reset();
    enable = 1'b1;
    last = 101 + 116 * 300;
    for (int n = 1; n <= last; n++) begin
      step();
      if (n == 100) begin
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL pll_timeout_hold: got %0d expected 1", state); end
        checks++; if (retry_cnt !== 8'd0) begin errors++; $display("FAIL pll_retry_before: got %0d expected 0", retry_cnt); end
      end
      if (n == 101) begin
        checks++; if (state !== 3'd7) begin errors++; $display("FAIL pll_backoff_entry: got %0d expected 7", state); end
        checks++; if (retry_cnt !== 8'd1) begin errors++; $display("FAIL pll_retry_first: got %0d expected 1", retry_cnt); end
        checks++; if (sfp_tx_disable !== 1'b1) begin errors++; $display("FAIL pll_backoff_disable: got %b expected 1", sfp_tx_disable); end
      end
      if (n == 116) begin
        checks++; if (state !== 3'd7) begin errors++; $display("FAIL pll_backoff_hold: got %0d expected 7", state); end
      end
      if (n == 117) begin
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL pll_backoff_exit: got %0d expected 1", state); end
      end
      if (n == 101 + 116 * 253) begin
        checks++; if (retry_cnt !== 8'd254) begin errors++; $display("FAIL pll_retry_254: got %0d expected 254", retry_cnt); end
      end
      if (n == 101 + 116 * 254) begin
        checks++; if (retry_cnt !== 8'd255) begin errors++; $display("FAIL pll_retry_255: got %0d expected 255", retry_cnt); end
      end
    end
    checks++; if (retry_cnt !== 8'd255) begin errors++; $display("FAIL pll_retry_saturate: got %0d expected 255", retry_cnt); end
  endtask

  task automatic test_link_drop();
    bit ok;
    enable = 1'b0; sfp_los = 1'b0;
    pll_lock = 1'b1; cdr_lock = 1'b1; block_lock = 1'b1;
    apply_reset();
    enable = 1'b1;
    wait_state(3'd6, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_reach_up: got state %0d expected 6", state); end
    sfp_los = 1'b1; cdr_lock = 1'b0;
    repeat (2) step();
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL drop_sync_latency: got link_up %b expected 1", link_up); end
    step();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL drop_state: got %0d expected 3", state); end
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL drop_link_up: got %b expected 0", link_up); end
    checks++; if (serdes_rx_rstn !== 1'b0) begin errors++; $display("FAIL drop_rx_rstn: got %b expected 0", serdes_rx_rstn); end
    checks++; if (serdes_tx_rstn !== 1'b1) begin errors++; $display("FAIL drop_tx_rstn: got %b expected 1", serdes_tx_rstn); end
  endtask

  task automatic test_disable_cdr_wait();
    bit ok;
    enable = 1'b0; sfp_los = 1'b0;
    pll_lock = 1'b1; cdr_lock = 1'b0; block_lock = 1'b1;
    apply_reset();
    enable = 1'b1;
    wait_state(3'd5, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dis_reach_cdr_wait: got state %0d expected 5", state); end
    repeat (2) step();
    enable = 1'b0;
    step();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL dis_state: got %0d expected 0", state); end
    checks++; if ({serdes_tx_rstn, serdes_rx_rstn, sfp_tx_disable} !== 3'b001) begin
      errors++; $display("FAIL dis_outputs: got %b expected 001", {serdes_tx_rstn, serdes_rx_rstn, sfp_tx_disable});
    end
    cdr_lock = 1'b1;
    repeat (3) step();
    enable = 1'b1;
    record(20);
    checks++; if (st_a[1] !== 3'd1) begin errors++; $display("FAIL reen_pll_wait: got %0d expected 1", st_a[1]); end
    checks++; if (st_a[5] !== 3'd2) begin errors++; $display("FAIL reen_tx_rst: got %0d expected 2", st_a[5]); end
    checks++; if (st_a[13] !== 3'd3) begin errors++; $display("FAIL reen_los_wait: got %0d expected 3", st_a[13]); end
    checks++; if (st_a[17] !== 3'd4) begin errors++; $display("FAIL reen_rx_rst: got %0d expected 4", st_a[17]); end
    checks++; if (st_a[18] !== 3'd5) begin errors++; $display("FAIL reen_cdr_wait: got %0d expected 5", st_a[18]); end
    checks++; if (lu_a[19] !== 1'b1) begin errors++; $display("FAIL reen_link_up: got %b expected 1", lu_a[19]); end
    checks++; if (sc_a[19] !== 1'b1) begin errors++; $display("FAIL reen_stats_clear: got %b expected 1", sc_a[19]); end
  endtask

  task automatic test_sync_reset_in_up();
    bit ok;
    enable = 1'b0; sfp_los = 1'b0;
    pll_lock = 1'b1; cdr_lock = 1'b1; block_lock = 1'b1;
    apply_reset();
    enable = 1'b1;
    wait_state(3'd6, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL srst_reach_up: got state %0d expected 6", state); end
    block_lock = 1'b0;
    wait_state(3'd7, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL srst_block_drop_backoff: got state %0d expected 7", state); end
    checks++; if (retry_cnt !== 8'd1) begin errors++; $display("FAIL srst_retry_one: got %0d expected 1", retry_cnt); end
    block_lock = 1'b1;
    wait_state(3'd6, 80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL srst_relink: got state %0d expected 6", state); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL srst_state: got %0d expected 0", state); end
    checks++; if ({serdes_tx_rstn, serdes_rx_rstn, sfp_tx_disable} !== 3'b001) begin
      errors++; $display("FAIL srst_pins: got %b expected 001", {serdes_tx_rstn, serdes_rx_rstn, sfp_tx_disable});
    end
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL srst_link_up: got %b expected 0", link_up); end
    checks++; if (stats_clear !== 1'b0) begin errors++; $display("FAIL srst_stats_clear: got %b expected 0", stats_clear); end
    checks++; if (retry_cnt !== 8'd0) begin errors++; $display("FAIL srst_retry: got %0d expected 0", retry_cnt); end
  endtask

  initial begin
    test_reset();
    test_clean_bringup();
    test_los_glitch();
    test_pll_never_locks();
    test_link_drop();
    test_disable_cdr_wait();
    test_sync_reset_in_up();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sfp_link_ctrl.md
# sfp_link_ctrl

Per-lane bring-up and recovery sequencer for one 10G SFP+ SerDes lane. It drives the lane's SerDes TX/RX reset and the SFP module's `sfp_tx_disable`. Bring-up proceeds through PLL lock, loss-of-signal debounce, and CDR/PCS block lock, with timeouts and back-off retry. The top level instantiates one per lane, in place of the static tie-offs. It also exports `link_up`, a state code and a retry count for LEDs/debug.

## Interface
- `RST_CYCLES`, 64: cycles each SerDes reset is held low in TX_RST / RX_RST (≥1).
- `LOS_DEBOUNCE`, 1024: consecutive cycles of synced `sfp_los`=0 required to leave LOS_WAIT (≥1).
- `LOCK_TIMEOUT`, 1000000: max cycles in PLL_WAIT or CDR_WAIT before BACKOFF (≥1).
- `BACKOFF_CYCLES`, 65536: cycles spent in BACKOFF (≥1).
- All four parameters ≤ 2^24−1. Shared 24-bit down-counter.

Ports:
- `clk` in 1: SerDes user/fabric clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: lane enable, `clk` domain; low forces OFF.
- `sfp_los` in 1: SFP loss-of-signal, asynchronous, 1 = no light.
- `pll_lock` in 1: SerDes PLL lock, asynchronous.
- `cdr_lock` in 1: SerDes RX CDR lock, asynchronous.
- `block_lock` in 1: 64b/66b PCS block lock, asynchronous.
- `serdes_tx_rstn` out 1: SerDes TX reset, active-low.
- `serdes_rx_rstn` out 1: SerDes RX reset, active-low.
- `sfp_tx_disable` out 1: SFP laser disable, 1 = off.
- `link_up` out 1: high only in UP.
- `stats_clear` out 1: one-cycle pulse on entry to UP; drives BER/block-error clear.
- `state` out 3: current state encoding.
- `retry_cnt` out 8: BACKOFF entries since reset; saturates at 255.

## Operation
- Each of the four asynchronous inputs passes through a 2-flop synchronizer. The FSM sees only synced values.
- All outputs are registered and decoded from the state register. `stats_clear` is a registered entry strobe.
- Output reset values: `serdes_tx_rstn`=0, `serdes_rx_rstn`=0, `sfp_tx_disable`=1, `link_up`=0, `stats_clear`=0, `state`=0, `retry_cnt`=0.
- Per-state outputs as (tx_rstn, rx_rstn, tx_disable):
  - 0 OFF (0,0,1). Go to PLL_WAIT when `enable`=1.
  - 1 PLL_WAIT (0,0,1). Go to TX_RST when pll_lock=1. After LOCK_TIMEOUT cycles without lock, go to BACKOFF.
  - 2 TX_RST (0,0,1). After RST_CYCLES cycles, go to LOS_WAIT.
  - 3 LOS_WAIT (1,0,0). Debounce counter restarts whenever los=1. After LOS_DEBOUNCE consecutive los=0 cycles, go to RX_RST. No timeout.
  - 4 RX_RST (1,0,0). After RST_CYCLES cycles, go to CDR_WAIT. If los=1, go to LOS_WAIT.
  - 5 CDR_WAIT (1,1,0). Go to UP when cdr_lock=1 and block_lock=1 in the same cycle. If los=1, go to LOS_WAIT. After LOCK_TIMEOUT cycles, go to BACKOFF.
  - 6 UP (1,1,0), `link_up`=1.
    - los=1: go to LOS_WAIT.
    - pll_lock=0: go to BACKOFF.
    - cdr_lock=0 or block_lock=0: go to BACKOFF.
  - 7 BACKOFF (0,0,1). After BACKOFF_CYCLES cycles, go to PLL_WAIT. `retry_cnt` increments on each entry, saturating at 255.
- Priority in every state: `rst` > `enable`=0 (go to OFF) > pll_lock=0 (from TX_RST onward, go to BACKOFF) > los=1 > the state's own condition.
  - Example: if los=1 and cdr_lock=0 arrive together in UP, the next state is LOS_WAIT.
  - A timeout and a success condition in the same cycle resolve to success.
- The counter reloads on every state change, so no stale count survives a re-entry.

## Timing
- Synchronizer latency is 2 cycles. Input edge at cycle n reaches the FSM at n+2, the next state at n+3, and the outputs at n+3.
- OFF→PLL_WAIT: the state changes on the edge after `enable` is sampled high.
- TX_RST and RX_RST each hold their reset low for exactly RST_CYCLES cycles measured at the outputs.
- LOS_WAIT: exits exactly LOS_DEBOUNCE cycles after the first synced los=0 of an unbroken run.
- Timeouts fire on cycle LOCK_TIMEOUT of residency in the state.
- BACKOFF lasts exactly BACKOFF_CYCLES cycles.
- `stats_clear` is high for exactly the first cycle `link_up` is high.
- `rst` or `enable`=0 mid-operation: outputs reach OFF values one cycle later.

## Test plan
Parameters for all scenarios: RST_CYCLES=4, LOS_DEBOUNCE=8, LOCK_TIMEOUT=100, BACKOFF_CYCLES=16.
1. Clean bring-up: enable=1 with pll_lock, cdr_lock and block_lock high and los=0 from the start. Required response: `serdes_tx_rstn` low for 4 cycles, `sfp_tx_disable` falls with tx_rstn release, rx_rstn rises after 8+4 more cycles, `link_up`=1, a single-cycle `stats_clear`, `retry_cnt`=0.
2. LOS glitch: in LOS_WAIT, pulse los=1 for 1 cycle after 6 los=0 cycles. Required response: the debounce restarts and RX_RST is entered only after 8 fresh los=0 cycles.
3. PLL never locks: pll_lock=0 throughout. Required response: BACKOFF after 100 cycles in PLL_WAIT, PLL_WAIT again after 16 cycles, `retry_cnt` increments; hold for 300 retries and check it saturates at 255.
4. Link drop in UP: drive los=1 and cdr_lock=0 in the same cycle. Required response: state=3, `link_up`=0 three cycles after the input edge, rx_rstn=0, tx_rstn=1.
5. Disable mid-CDR_WAIT: enable=0. Required response: outputs (0,0,1), state=0 on the next edge; re-enable repeats the scenario-1 sequence.
6. Synchronous reset during UP: `rst`=1 for 1 cycle. Required response: all outputs at reset values, `retry_cnt`=0.
